rotate_seq_ctrl: RTL
====================

Name: rotate_seq_ctrl

Overview:
Sequencer for the 8-bit parallel-load/rotate-right register.
- The register has load-select `SL`, parallel input `pin[7:0]` and output `Q[7:0]`.
- Its next-state rule is: `SL=1` gives `Q<=pin`; `SL=0` gives `Q[i]<=Q[i+1]` and `Q[7]<=Q[0]`.
- The register has no hold mode. This block creates one by reloading `Q` onto itself.
- The block loads a start pattern, then performs either N rotations or continuous rotation, paced by a clock prescaler. It reports the final register contents. Used for LED marquee and serializer labs on the board.

Parameters:
- DIV, 4, clock cycles per rotation step; legal range ≥1; DIV=1 rotates every cycle.
- STEP_W, 4, width of the step-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- pattern  input  8  pattern loaded on start.
- steps  input  STEP_W  number of rotations; ignored when continuous=1.
- continuous  input  1  1 = rotate until stop; sampled with start.
- stop  input  1  ends rotation; honoured only in ROTATE.
- q  input  8  feedback from register Q.
- sl  output  1  drives register SL.
- pin  output  8  drives register pin.
- busy  output  1  high whenever state≠IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  8  register contents captured at completion.

Behaviour:
- States: IDLE, LOAD, ROTATE, DONE. Encoding is free.
- sl/pin are combinational from state and tick:
  - rst=1 → sl=1, pin=8'h00. The register clears while reset is held.
  - LOAD → sl=1, pin=pattern_r.
  - ROTATE with tick=1 → sl=0. pin is don't-care; drive q.
  - All other cases (IDLE, DONE, ROTATE with tick=0) → sl=1, pin=q. This is the hold.
- Reset values: state=IDLE, busy=0, done=0, result=8'h00, divcnt=0, remaining=0, pattern_r=0, cont_r=0.
- IDLE:
  - start=1 → latch pattern_r, remaining=steps, cont_r=continuous; go to LOAD.
  - start in any other state is ignored. No queuing.
- LOAD (exactly 1 cycle): the register takes pattern_r at the end of this cycle. divcnt←0.
  - cont_r=0 and remaining=0 → DONE.
  - Otherwise → ROTATE.
- ROTATE:
  - divcnt counts 0..DIV-1 and wraps. tick = (divcnt==DIV-1).
  - On tick, exactly one rotation occurs. If cont_r=0, remaining decrements.
  - cont_r=0, tick, and remaining==1 → DONE.
  - stop=1 has priority over tick. Go to DONE with sl=1 that cycle, so no rotation occurs.
  - stop is ignored in IDLE, LOAD and DONE.
- DONE (1 cycle): register held. At the closing edge: result←q, done←1, state→IDLE.
- done is registered: high for exactly the first IDLE cycle after DONE, low otherwise.
- A start arriving in that same IDLE cycle is accepted normally.
- Latency (start sampled at edge E0, cont=0, steps=N≥1): LOAD 1 cycle + ROTATE N·DIV cycles + DONE 1 cycle. done and result are valid N·DIV+2 cycles after E0.
- steps=0: done is valid 2 cycles after E0, with result=pattern.
- remaining never underflows. Decrement occurs only when remaining≥1.
- Max count is 2^STEP_W−1 rotations.
- rst mid-operation: on the next edge return to IDLE, busy=0, done=0, and the register clears to 0. Any in-flight job is discarded with no done pulse.
- q is trusted as the register's current value. No consistency checking is performed.

Test Plan:
1. DIV=1. rst held 2 cycles with register preset 0xFF → q=0x00, busy=0, done=0, result=0x00.
2. DIV=1, start with pattern=0x01, steps=3 → register sequence 0x01,0x80,0x40,0x20. done pulses 1 cycle, 5 cycles after start edge. result=0x20. busy high 5 cycles.
3. DIV=4, pattern=0xA5, steps=1 → q stays 0xA5 for 3 ROTATE cycles, then becomes 0xD2. done 6 cycles after start, result=0xD2. Then steps=8 from 0xA5 → result=0xA5.
4. steps=0, pattern=0x3C → no rotation, done 2 cycles after start, result=0x3C. Also: start pulses while busy → ignored, with exactly one done pulse.
5. DIV=1, continuous=1, pattern=0x81 → rotates every cycle (0x81,0xC0,0x60,…). stop coincident with tick → no rotation that cycle, done next-next cycle, result equals q at stop.
6. rst asserted mid-ROTATE (steps=10, DIV=2) → next cycle IDLE, q=0x00, no done pulse. A following start with 0x0F, steps=2 completes normally with result=0xC3.

Source files
------------

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: sequencer for an external 8-bit parallel-load / rotate-right
// register. It loads a start pattern and then rotates it either a fixed number
// of times or until stopped. Rotation steps are paced by a DIV-cycle prescaler.
// The register has no hold mode, so holding is done by reloading q onto itself.
// When a job ends, the final register contents are reported on result.
module rotate_seq_ctrl #(
    parameter int DIV    = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pattern,
    input  logic [STEP_W-1:0] steps,
    input  logic              continuous,
    input  logic              stop,
    input  logic [7:0]        q,
    output logic              sl,
    output logic [7:0]        pin,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result
);

    localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [STEP_W-1:0] ONE_STEP = STEP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROTATE,
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  divcnt_q,    divcnt_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [7:0]        pattern_r_q, pattern_r_d;
    logic              cont_r_q,    cont_r_d;
    logic              done_q,      done_d;
    logic [7:0]        result_q,    result_d;
    logic              tick;

    // A rotation step is due on the last cycle of each prescaler period.
    assign tick = (state_q == S_ROTATE) && (divcnt_q == DIV_LAST);

    // Register control: reload q (hold) unless loading, clearing, or rotating.
    // A stop request wins over a due tick, so no rotation happens that cycle.
    always_comb begin
        sl  = 1'b1;
        pin = q;
        if (rst) begin
            pin = 8'h00;
        end else if (state_q == S_LOAD) begin
            pin = pattern_r_q;
        end else if (tick && !stop) begin
            sl = 1'b0;
        end
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d     = state_q;
        divcnt_d    = divcnt_q;
        remaining_d = remaining_q;
        pattern_r_d = pattern_r_q;
        cont_r_d    = cont_r_q;
        done_d      = 1'b0;
        result_d    = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pattern_r_d = pattern;
                    remaining_d = steps;
                    cont_r_d    = continuous;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                divcnt_d = '0;
                if (!cont_r_q && (remaining_q == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    divcnt_d = '0;
                    if (!cont_r_q && (remaining_q != '0)) begin
                        remaining_d = remaining_q - ONE_STEP;
                    end
                    if (!cont_r_q && (remaining_q == ONE_STEP)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                result_d = q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            divcnt_q    <= '0;
            remaining_q <= '0;
            pattern_r_q <= 8'h00;
            cont_r_q    <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            divcnt_q    <= divcnt_d;
            remaining_q <= remaining_d;
            pattern_r_q <= pattern_r_d;
            cont_r_q    <= cont_r_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
